prod_accum: RTL and testbench



---
 rtl/mult_pkg.sv | 15 +
 rtl/prod_accum_add.sv | 24 ++
 rtl/prod_accum.sv | 111 +++++++++++
 tb/tb_prod_accum.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath and its product accumulator:
// FSM state encodings and default datapath widths.
package mult_pkg;

  localparam int WIDTH_DEF     = 4;   // multiplier operand width
  localparam int ACC_WIDTH_DEF = 16;  // accumulator width, >= 2*WIDTH
  localparam int CNT_WIDTH_DEF = 4;   // term-count field width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : mult_pkg

// File: rtl/prod_accum_add.sv
// N-bit ripple-carry adder assembled from 1-bit full adders.
// Used by prod_accum to add a zero-extended product to the accumulator.
module prod_accum_add #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  // One full adder per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule : prod_accum_add

// File: rtl/prod_accum.sv
// Product accumulator: sums a programmed number of unsigned products into a
// wider accumulator and presents the result with a sticky overflow flag.
// Optional feature: define PROD_ACCUM_SAT_EN to saturate the accumulator at
// all-ones on carry-out instead of wrapping.
module prod_accum
  import mult_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,  // must be >= 2*WIDTH
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   len,
  input  logic                   in_valid,
  input  logic [2*WIDTH-1:0]     in_prod,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic                   out_ovf,
  input  logic                   out_ready,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;

  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   carry_out;

  assign prod_ext = ACC_WIDTH'(in_prod);

  prod_accum_add #(.N(ACC_WIDTH)) u_add (
    .a    (acc_q),
    .b    (prod_ext),
    .sum  (sum),
    .cout (carry_out)
  );

  // Next-state, accumulator and counter update for the IDLE/ACC/DONE sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    remaining_d = remaining_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d       = '0;
          ovf_d       = 1'b0;
          remaining_d = len;
          state_d     = (len == '0) ? ST_DONE : ST_ACC;
        end
      end

      ST_ACC: begin
        if (in_valid) begin
`ifdef PROD_ACCUM_SAT_EN
          // Once clamped, stay at all-ones for the rest of the accumulation.
          acc_d = (carry_out || ovf_q) ? '1 : sum;
`else
          acc_d = sum;
`endif
          ovf_d       = ovf_q | carry_out;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any accumulation and discards the partial sum.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      remaining_q <= remaining_d;
    end
  end

  // Outputs are decoded from registers only; no input reaches them combinationally.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule : prod_accum

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: a 16-bit accumulator instance and an
// 8-bit one share stimulus so the overflow cases are reachable.
// Build with PROD_ACCUM_SAT_EN defined to check the saturating variant.
module tb_prod_accum;

`ifdef PROD_ACCUM_SAT_EN
  localparam logic [7:0] ACC8_OVF2  = 8'd255;
  localparam logic [7:0] ACC8_MAXLN = 8'd255;
`else
  localparam logic [7:0] ACC8_OVF2  = 8'd44;   // 300 mod 256
  localparam logic [7:0] ACC8_MAXLN = 8'd47;   // 3375 mod 256
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic [7:0]  in_prod;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf, busy;
  logic [15:0] out_acc;
  logic        in_ready8, out_valid8, out_ovf8, busy8;
  logic [7:0]  out_acc8;

  prod_accum u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .busy      (busy)
  );

  prod_accum #(.ACC_WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_ready  (in_ready8),
    .out_valid (out_valid8),
    .out_acc   (out_acc8),
    .out_ovf   (out_ovf8),
    .out_ready (out_ready),
    .busy      (busy8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int start_edge  = 0;
  int lat_meas    = 0;
  bit valid_seen  = 1'b0;

  typedef struct {
    logic [15:0] acc;
    logic        ovf;
    logic [7:0]  acc8;
    logic        ovf8;
    int          lat;   // expected start-to-valid cycles; 0 = not checked
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start_edge = cyc;
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] p, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_prod  = p;
    check("in_ready_before_product", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("return_to_idle", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_out_acc"},    out_acc,    0);
    check({tag, "_out_ovf"},    out_ovf,    0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_out_valid8"}, out_valid8, 0);
    check({tag, "_out_acc8"},   out_acc8,   0);
  endtask

  function automatic exp_t mk(input logic [15:0] a, input logic o, input logic [7:0] a8,
                              input logic o8, input int lat);
    exp_t e;
    e.acc = a; e.ovf = o; e.acc8 = a8; e.ovf8 = o8; e.lat = lat;
    return e;
  endfunction

  // Monitor: records first-valid latency and checks each result at its handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && !valid_seen) begin
      valid_seen = 1'b1;
      lat_meas   = cyc - start_edge + 1;
    end
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("result_without_expectation", 32'(sb_q.size() != 0), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_acc",    out_acc,    e.acc);
        check("out_ovf",    out_ovf,    e.ovf);
        check("out_valid8", out_valid8, 1);
        check("out_acc8",   out_acc8,   e.acc8);
        check("out_ovf8",   out_ovf8,   e.ovf8);
        if (e.lat != 0) check("start_to_valid_cycles", lat_meas, e.lat);
      end
      valid_seen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
    tick(); tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();

    // Reset mid-operation: two of three products in, then abort.
    issue_start(4'd3);
    feed(8'd9, 0);
    feed(8'd9, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    tick();
    rst = 1'b0;
    tick();
    sb_q.push_back(mk(16'd9, 1'b0, 8'd9, 1'b0, 2));
    issue_start(4'd1);
    feed(8'd9, 0);
    wait_idle();

    // Basic sum with in_valid held high.
    sb_q.push_back(mk(16'd246, 1'b0, 8'd246, 1'b0, 5));
    issue_start(4'd4);
    feed(8'd6, 0);
    feed(8'd15, 0);
    feed(8'd225, 0);
    feed(8'd0, 0);
    wait_idle();
    check("out_acc_holds_in_idle", out_acc, 246);

    // Bubbles between products, then backpressure on the result.
    out_ready = 1'b0;
    sb_q.push_back(mk(16'd30, 1'b0, 8'd30, 1'b0, 0));
    issue_start(4'd2);
    feed(8'd10, 0);
    feed(8'd20, 3);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    repeat (4) begin
      check("backpressure_out_valid", out_valid, 1);
      check("backpressure_out_acc",   out_acc,   30);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // Zero length, then a start pulse during DONE that must be ignored.
    out_ready = 1'b0;
    sb_q.push_back(mk(16'd0, 1'b0, 8'd0, 1'b0, 1));
    issue_start(4'd0);
    check("len0_out_valid", out_valid, 1);
    check("len0_out_acc",   out_acc,   0);
    start = 1'b1;
    len   = 4'd5;
    tick();
    start = 1'b0;
    check("done_start_out_valid", out_valid, 1);
    check("done_start_in_ready",  in_ready,  0);
    check("done_start_out_acc",   out_acc,   0);
    tick();
    check("done_start_still_done", out_valid, 1);
    out_ready = 1'b1;
    wait_idle();
    check("idle_after_ignored_start", in_ready, 0);

    // Overflow on the 8-bit instance: 200 + 100.
    sb_q.push_back(mk(16'd300, 1'b0, ACC8_OVF2, 1'b1, 3));
    issue_start(4'd2);
    feed(8'd200, 0);
    feed(8'd100, 0);
    wait_idle();

    // Maximum length: fifteen products of 225.
    sb_q.push_back(mk(16'd3375, 1'b0, ACC8_MAXLN, 1'b1, 16));
    issue_start(4'd15);
    repeat (15) feed(8'd225, 0);
    wait_idle();

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 20) begin
        tick();
        n++;
      end
    end
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_prod_accum
